// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Optional result flags are enabled by defining ALU_SCHED_FLAGS_EN.
package alu_sched_pkg;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned FXN_W  = 3;

    localparam logic [FXN_W-1:0] FXN_PASS_A = 3'b000;
    localparam logic [FXN_W-1:0] FXN_PASS_B = 3'b001;
    localparam logic [FXN_W-1:0] FXN_NEG_A  = 3'b010;
    localparam logic [FXN_W-1:0] FXN_NEG_B  = 3'b011;
    localparam logic [FXN_W-1:0] FXN_GT     = 3'b100;
    localparam logic [FXN_W-1:0] FXN_XNOR   = 3'b101;
    localparam logic [FXN_W-1:0] FXN_ADD    = 3'b110;
    localparam logic [FXN_W-1:0] FXN_SUB    = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu6_exec.sv
// Purely combinational 6-bit ALU: fxn/A/B -> result.
// With ALU_SCHED_FLAGS_EN defined it also reports zero and signed overflow.
module alu6_exec
    import alu_sched_pkg::*;
(
    input  logic [FXN_W-1:0]  i_fxn,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
`ifdef ALU_SCHED_FLAGS_EN
    output logic              o_zero,
    output logic              o_ovf,
`endif
    output logic [DATA_W-1:0] o_result
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] w_neg_a;
    logic [DATA_W-1:0] w_neg_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;

    assign w_neg_a = DATA_W'(0) - i_a;
    assign w_neg_b = DATA_W'(0) - i_b;
    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;

    always_comb begin
        o_result = '0;
        case (i_fxn)
            FXN_PASS_A: o_result = i_a;
            FXN_PASS_B: o_result = i_b;
            FXN_NEG_A:  o_result = w_neg_a;
            FXN_NEG_B:  o_result = w_neg_b;
            FXN_GT:     o_result = {{(DATA_W-1){1'b0}}, (i_a > i_b)};
            FXN_XNOR:   o_result = ~(i_a ^ i_b);
            FXN_ADD:    o_result = w_sum;
            FXN_SUB:    o_result = w_diff;
            default:    o_result = '0;
        endcase
    end

`ifdef ALU_SCHED_FLAGS_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    assign o_zero = (o_result == '0);

    // Negating the most negative value is the only unary overflow case.
    always_comb begin
        o_ovf = 1'b0;
        case (i_fxn)
            FXN_NEG_A: o_ovf = (i_a == MOST_NEG);
            FXN_NEG_B: o_ovf = (i_b == MOST_NEG);
            FXN_ADD:   o_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            FXN_SUB:   o_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            default:   o_ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_op_scheduler.sv
// Round-robin arbiter and IDLE/EXEC/HOLD sequencer sharing one 6-bit ALU between two requesters.
// Define ALU_SCHED_FLAGS_EN to add registered res_zero/res_ovf outputs.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [FXN_W-1:0]  req0_fxn,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [FXN_W-1:0]  req1_fxn,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_src,
`ifdef ALU_SCHED_FLAGS_EN
    output logic              res_zero,
    output logic              res_ovf,
`endif
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_win;

    logic              r_last_grant;
    logic [FXN_W-1:0]  r_fxn;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_src;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_src;
    logic [CNT_W-1:0]  r_op_count;
    logic              r_busy;
    logic [DATA_W-1:0] w_alu_res;

`ifdef ALU_SCHED_FLAGS_EN
    logic              w_alu_zero;
    logic              w_alu_ovf;
    logic              r_res_zero;
    logic              r_res_ovf;
`endif

    alu6_exec u_alu (
        .i_fxn    (r_fxn),
        .i_a      (r_a),
        .i_b      (r_b),
`ifdef ALU_SCHED_FLAGS_EN
        .o_zero   (w_alu_zero),
        .o_ovf    (w_alu_ovf),
`endif
        .o_result (w_alu_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration and next state; contention goes to the requester not granted last.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_win       = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_accept = 1'b1;
                    w_win    = ~r_last_grant;
                end else if (req0_valid) begin
                    w_accept = 1'b1;
                    w_win    = 1'b0;
                end else if (req1_valid) begin
                    w_accept = 1'b1;
                    w_win    = 1'b1;
                end
                if (w_accept) begin
                    req0_ready  = ~w_win;
                    req1_ready  = w_win;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = HOLD;
            HOLD: begin
                if (r_res_valid && res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_fxn        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_src        <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_src    <= 1'b0;
            r_op_count   <= '0;
            r_busy       <= 1'b0;
`ifdef ALU_SCHED_FLAGS_EN
            r_res_zero   <= 1'b0;
            r_res_ovf    <= 1'b0;
`endif
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_fxn        <= w_win ? req1_fxn : req0_fxn;
                r_a          <= w_win ? req1_a   : req0_a;
                r_b          <= w_win ? req1_b   : req0_b;
                r_src        <= w_win;
                r_last_grant <= w_win;
            end
            if (r_state == EXEC) begin
                r_res_data  <= w_alu_res;
                r_res_src   <= r_src;
                r_res_valid <= 1'b1;
`ifdef ALU_SCHED_FLAGS_EN
                r_res_zero  <= w_alu_zero;
                r_res_ovf   <= w_alu_ovf;
`endif
            end
            if ((r_state == HOLD) && r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
                r_op_count  <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_src   = r_res_src;
    assign busy      = r_busy;
    assign op_count  = r_op_count;
`ifdef ALU_SCHED_FLAGS_EN
    assign res_zero  = r_res_zero;
    assign res_ovf   = r_res_ovf;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler; flag checks compile in with ALU_SCHED_FLAGS_EN.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [FXN_W-1:0]  req0_fxn, req1_fxn;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              res_valid, res_ready, res_src, busy;
    logic [DATA_W-1:0] res_data;
    logic [CNT_W-1:0]  op_count;
`ifdef ALU_SCHED_FLAGS_EN
    logic              res_zero, res_ovf;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int n_accept = 0;
    int exp_cnt  = 0;
    logic exp_lg = 1'b1;
    logic [8:0] sb_q[$];   // {ovf, zero, src, data}
    logic [6:0] got_q[$];  // {src, data} of completed handshakes

    always #5 clk = ~clk;

    alu_op_scheduler #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_fxn   (req0_fxn),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_fxn   (req1_fxn),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_src    (res_src),
`ifdef ALU_SCHED_FLAGS_EN
        .res_zero   (res_zero),
        .res_ovf    (res_ovf),
`endif
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU in signed integer arithmetic.
    function automatic logic [8:0] model(input logic [2:0] f, input logic [5:0] a,
                                         input logic [5:0] b, input logic src);
        int sa, sb, r;
        logic ovf;
        logic [5:0] d;
        logic [5:0] x;
        sa  = a[5] ? int'(a) - 64 : int'(a);
        sb  = b[5] ? int'(b) - 64 : int'(b);
        x   = ~(a ^ b);
        ovf = 1'b0;
        r   = 0;
        case (f)
            3'd0: r = sa;
            3'd1: r = sb;
            3'd2: begin r = -sa;     ovf = (r > 31); end
            3'd3: begin r = -sb;     ovf = (r > 31); end
            3'd4: r = (int'(a) > int'(b)) ? 1 : 0;
            3'd5: r = int'(x);
            3'd6: begin r = sa + sb; ovf = (r > 31) || (r < -32); end
            default: begin r = sa - sb; ovf = (r > 31) || (r < -32); end
        endcase
        d = 6'(r);
        return {ovf, (d == 6'd0), src, d};
    endfunction

    // Arbitration model, scoreboard push on accept, compare/pop on result.
    always @(negedge clk) begin : mon_blk
        logic e0, e1;
        logic [8:0] ent;
        if (!rst_n) begin
            sb_q.delete();
            exp_lg  = 1'b1;
            exp_cnt = 0;
        end else begin
            e0 = !busy && req0_valid && (!req1_valid || exp_lg);
            e1 = !busy && req1_valid && (!req0_valid || !exp_lg);
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("op_count", 32'(op_count), 32'(exp_cnt));
            if (res_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_result", 32'(res_data), 32'hFFFF);
                end else begin
                    ent = sb_q[0];
                    chk("res_data", 32'(res_data), 32'(ent[5:0]));
                    chk("res_src", 32'(res_src), 32'(ent[6]));
`ifdef ALU_SCHED_FLAGS_EN
                    chk("res_zero", 32'(res_zero), 32'(ent[7]));
                    chk("res_ovf", 32'(res_ovf), 32'(ent[8]));
`endif
                    if (res_ready) begin
                        void'(sb_q.pop_front());
                        got_q.push_back({res_src, res_data});
                        exp_cnt = (exp_cnt + 1) % 256;
                    end
                end
            end
            if (e0 || e1) begin
                sb_q.push_back(e1 ? model(req1_fxn, req1_a, req1_b, 1'b1)
                                  : model(req0_fxn, req0_a, req0_b, 1'b0));
                exp_lg = e1;
                n_accept++;
            end
        end
    end

    task automatic wait_accepts(input int target);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (n_accept >= target) return;
        end
        chk("accept_timeout", 32'(n_accept), 32'(target));
    endtask

    task automatic wait_result(input int exp_d, input int exp_s, input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_valid) begin
                chk({tag, "_data"}, 32'(res_data), 32'(exp_d));
                chk({tag, "_src"}, 32'(res_src), 32'(exp_s));
                return;
            end
        end
        chk({tag, "_timeout"}, 32'(res_valid), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && !res_valid) return;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [5:0] a, input logic [5:0] b,
                          input int exp_d, input string tag);
        int t;
        wait_idle();
        @(posedge clk); #1;
        req0_fxn = f; req0_a = a; req0_b = b; req0_valid = 1'b1;
        t = n_accept;
        wait_accepts(t + 1);
        #1 req0_valid = 1'b0;
        wait_result(exp_d, 0, tag);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_fxn = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_fxn = '0; req1_a = '0; req1_b = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_src", 32'(res_src), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op_count", 32'(op_count), 0);

        // Single SUB from requester 0 with latency check.
        @(posedge clk); #1;
        req0_fxn = 3'b111; req0_a = 6'd18; req0_b = 6'd19; req0_valid = 1'b1;
        t = n_accept;
        wait_accepts(t + 1);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("lat_exec_valid", 32'(res_valid), 0);
        chk("lat_exec_busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat_hold_valid", 32'(res_valid), 1);
        chk("sub_data", 32'(res_data), 63);
        chk("sub_src", 32'(res_src), 0);
        @(negedge clk);
        chk("sub_op_count", 32'(op_count), 1);
        chk("sub_done_valid", 32'(res_valid), 0);

        // Contention after reset: req0, req1, req0.
        pulse_reset();
        got_q.delete();
        req0_fxn = 3'b110; req0_a = 6'd18; req0_b = 6'd19; req0_valid = 1'b1;
        req1_fxn = 3'b101; req1_a = 6'd18; req1_b = 6'd19; req1_valid = 1'b1;
        t = n_accept;
        wait_accepts(t + 3);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("rr_count", 32'(got_q.size()), 3);
        if (got_q.size() >= 3) begin
            chk("rr_first", 32'(got_q[0]), 32'({1'b0, 6'd37}));
            chk("rr_second", 32'(got_q[1]), 32'({1'b1, 6'd62}));
            chk("rr_third", 32'(got_q[2]), 32'({1'b0, 6'd37}));
        end

        // Consumer stalls 10 cycles in HOLD while both requesters wait.
        @(posedge clk); #1;
        res_ready = 1'b0;
        req1_fxn = 3'b000; req1_a = 6'd5;  req1_b = 6'd0; req1_valid = 1'b1;
        req0_fxn = 3'b001; req0_a = 6'd0;  req0_b = 6'd9; req0_valid = 1'b1;
        wait_result(5, 1, "hold_first");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_data", 32'(res_data), 5);
            chk("hold_src", 32'(res_src), 1);
            chk("hold_rdy0", 32'(req0_ready), 0);
            chk("hold_rdy1", 32'(req1_ready), 0);
            chk("hold_busy", 32'(busy), 1);
            chk("hold_cnt", 32'(op_count), 3);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        t = n_accept;
        wait_accepts(t + 1);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_result(9, 0, "hold_next");

        // Unary and compare functions.
        run_op(3'b010, 6'd18, 6'd0,  46, "neg_a");
        run_op(3'b011, 6'd0,  6'd1,  63, "neg_b");
        run_op(3'b100, 6'd19, 6'd18, 1,  "gt_true");
        run_op(3'b100, 6'd18, 6'd19, 0,  "gt_false");

        // Reset while EXEC; last grant was req0 so req1 wins before reset, req0 after.
        wait_idle();
        @(posedge clk); #1;
        req0_fxn = 3'b110; req0_a = 6'd1; req0_b = 6'd2; req0_valid = 1'b1;
        req1_fxn = 3'b000; req1_a = 6'd7; req1_b = 6'd0; req1_valid = 1'b1;
        t = n_accept;
        wait_accepts(t + 1);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_exec_busy", 32'(busy), 0);
        chk("rst_exec_valid", 32'(res_valid), 0);
        chk("rst_exec_cnt", 32'(op_count), 0);
        chk("rst_exec_rdy0", 32'(req0_ready), 1);
        chk("rst_exec_rdy1", 32'(req1_ready), 0);
        t = n_accept;
        wait_accepts(t + 1);
        #1 req0_valid = 1'b0;
        wait_result(3, 0, "rst_regrant0");
        t = n_accept;
        wait_accepts(t + 1);
        #1 req1_valid = 1'b0;
        wait_result(7, 1, "rst_regrant1");

`ifdef ALU_SCHED_FLAGS_EN
        run_op(3'b110, 6'd31, 6'd1, 32, "flag_add");
        chk("flag_add_ovf", 32'(res_ovf), 1);
        chk("flag_add_zero", 32'(res_zero), 0);
        run_op(3'b111, 6'd5, 6'd5, 0, "flag_sub");
        chk("flag_sub_zero", 32'(res_zero), 1);
        chk("flag_sub_ovf", 32'(res_ovf), 0);
        run_op(3'b010, 6'd32, 6'd0, 32, "flag_neg");
        chk("flag_neg_ovf", 32'(res_ovf), 1);
`endif

        wait_idle();
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
